rsp_xreturn: RTL and testbench
==============================

# rsp_xreturn

Response-return router for the generated crossbar: the reverse path of the request arbiter. It records, per target, the ordered list of initiators whose requests were granted, and steers each target's multi-beat response back to its owner. Each initiator has a round-robin arbiter over the targets that currently hold a response for it. A burst is locked to one initiator until its last beat. Data is not stored here; `I_rsp_sel` drives the external per-initiator response mux.

## Interface
Parameters:
- `N_INI`, 3: number of initiators.
- `N_TGT`, 5: number of targets.
- `MAX_OUT`, 4: outstanding requests per target (owner FIFO depth, ≥2).

Ports:
- `clk`  in  1: clock. One clock domain only.
- `rstn`  in  1: reset, asynchronous, active-low.
- `I_vreq`  in  [N_INI][N_TGT]: granted and accepted requests from the request arbiter.
  - Each row is onehot0.
  - Each column is onehot0.
- `T_ord_full`  out  [N_TGT]: owner FIFO of target t is full. The switch ANDs `~T_ord_full` into `T_rdy`.
- `T_rsp_vld`  in  [N_TGT]: target t presents a response beat.
- `T_rsp_last`  in  [N_TGT]: that beat is the last of its burst.
- `T_rsp_rdy`  out  [N_TGT]: beat from target t accepted.
- `I_rsp_vld`  out  [N_INI]: response beat valid toward initiator i.
- `I_rsp_sel`  out  [N_INI][N_TGT]: onehot0 source target for initiator i. Non-zero iff `I_rsp_vld[i]`.
- `I_rsp_rdy`  in  [N_INI]: initiator i accepts the beat.

## Operation
- **Owner capture:** when `I_vreq[i][t]`=1, push initiator ID i into owner FIFO t that cycle. Requests to a target are served in order, so FIFO head = owner of target t's current response.
- **Candidates:** initiator i's candidates are targets t with `T_rsp_vld[t]`, FIFO t non-empty, and head(t)==i.
- **Unlocked arbitration:** initiator i picks the first candidate strictly after `ptr[i]`, scanning upward and wrapping modulo N_TGT.
- **Locked arbitration:** if `lock_vld[i]`, the only eligible target is `lock_tgt[i]`, whether or not other candidates exist.
- **Handshake:** fires on `I_rsp_vld[i] & I_rsp_rdy[i]`. For granted target t, `T_rsp_rdy[t] = I_rsp_rdy[i]`. Non-granted targets have `T_rsp_rdy`=0.
- **On a handshake with `last`=0:**
  - set `lock_vld[i]`=1 and `lock_tgt[i]`=t;
  - if this is the first beat (unlocked), set `ptr[i]`=t.
- **On a handshake with `last`=1:**
  - pop FIFO t and clear `lock_vld[i]`;
  - if this is a single-beat burst, set `ptr[i]`=t.
- **Orphan beat:** `T_rsp_vld` with FIFO empty gets `T_rsp_rdy`=0 and fires a non-synthesis assertion.
- **Full-FIFO push:** `I_vreq` into a full FIFO fires an assertion, and the push is dropped.
- **Width rule:** owner ID width = $clog2(N_INI). Count width = $clog2(MAX_OUT+1).

## Timing
- **Reset values:**
  - all FIFOs empty, `lock_vld`=0, `ptr[i]`=N_TGT-1 (target 0 has first priority);
  - hence `T_ord_full`=0, `T_rsp_rdy`=0, `I_rsp_vld`=0, `I_rsp_sel`=0.
- **Outputs:** `I_rsp_vld`, `I_rsp_sel` and `T_rsp_rdy` are combinational from state plus `T_rsp_*` and `I_rsp_rdy`. Zero added latency for response beats.
- **Push visibility:** a push is visible at the FIFO head the next cycle. The earliest accepted response is one cycle after its request is granted; there is no same-cycle bypass.
- **`T_ord_full`:** registered-state decode, count==MAX_OUT. A pop does not clear full in the same cycle, so no pass-through credit.
- **Simultaneous push and pop on one FIFO:** count unchanged, head advances.
- **Simultaneous pop on several targets** (to different initiators): independent.
- **Wrap-around:** FIFO pointers wrap modulo MAX_OUT, and `ptr` wraps modulo N_TGT.
- **Reset mid-burst:** all ownership and locks are discarded immediately. Outstanding transactions are lost, and the system resets the targets together with this block.

## Structure
- **Shared package `xswitch_pkg`:** default `N_INI`, `N_TGT`, `MAX_OUT` localparams, plus `ini_id_t` typedef (logic [$clog2(N_INI)-1:0]).
- **Sub-module `rsp_owner_fifo`:** parameters depth and width. Ports: push, push data, pop, head, empty, full. Instantiated N_TGT times.
- **Inline logic:** per-initiator RR/lock logic is inline, in a generate loop over N_INI.

## Test plan
- **Single beat:** after reset, `I_vreq[1][3]`=1 for one cycle. Next cycle `T_rsp_vld[3]`=1, `last`=1, `I_rsp_rdy[1]`=1 → `I_rsp_vld[1]`=1, `I_rsp_sel[1]`=5'b01000, `T_rsp_rdy[3]`=1. FIFO 3 is empty afterwards.
- **Burst lock:**
  - Setup: initiator 0 owns targets 0 and 2. Target 2 sends 3 beats (last on the 3rd) while target 0 is also valid.
  - Required: `I_rsp_sel[0]` stays at target 2 for all 3 beats, then switches to target 0.
- **Round-robin:** initiator 2 owns targets 1 and 4, both single-beat valid continuously, with `ptr` at reset. Grant order is 1, 4.
- **Full/back-pressure and order:**
  - Setup: push 4 requests into target 0 (from initiators 0,1,2,0), with no response.
  - Required after the pushes: `T_ord_full[0]`=1.
  - Required on return: responses go to initiators 0,1,2,0 in order, and `T_ord_full[0]` drops the cycle after the first pop.
- **Stall:** `I_rsp_rdy[1]`=0 with a valid beat for initiator 1 → `T_rsp_rdy`=0 and state unchanged. Orphan `T_rsp_vld[4]` with FIFO empty → `T_rsp_rdy[4]`=0 and the assertion fires.
- **Reset mid-burst:** after the 1st of 3 beats, pull `rstn` low → all outputs 0 immediately, and `lock_vld` is clear after release.

Source files
------------

// File: rtl/xswitch_pkg.sv
// xswitch_pkg: crossbar-wide default sizes, owner ID type and the round-robin index helper.
package xswitch_pkg;
  localparam int N_INI = 3;
  localparam int N_TGT = 5;
  localparam int MAX_OUT = 4;
  typedef logic [$clog2(N_INI)-1:0] ini_id_t;
  function automatic int rr_idx(int base, int step, int n);
    return base + step >= n ? base + step - n : base + step;
  endfunction
endpackage

// File: rtl/rsp_xreturn_if.sv
// rsp_xreturn_if: grant capture, target response handshake and initiator response steering bundle.
interface rsp_xreturn_if #(
  parameter int N_INI = xswitch_pkg::N_INI,
  parameter int N_TGT = xswitch_pkg::N_TGT
);
  import xswitch_pkg::*;
  logic [N_INI-1:0][N_TGT-1:0] I_vreq;
  logic [N_TGT-1:0] T_ord_full;
  logic [N_TGT-1:0] T_rsp_vld;
  logic [N_TGT-1:0] T_rsp_last;
  logic [N_TGT-1:0] T_rsp_rdy;
  logic [N_INI-1:0] I_rsp_vld;
  logic [N_INI-1:0][N_TGT-1:0] I_rsp_sel;
  logic [N_INI-1:0] I_rsp_rdy;
  modport master (
    output I_vreq, T_rsp_vld, T_rsp_last, I_rsp_rdy,
    input  T_ord_full, T_rsp_rdy, I_rsp_vld, I_rsp_sel
  );
  modport slave (
    input  I_vreq, T_rsp_vld, T_rsp_last, I_rsp_rdy,
    output T_ord_full, T_rsp_rdy, I_rsp_vld, I_rsp_sel
  );
endinterface

// File: rtl/rsp_owner_fifo.sv
// rsp_owner_fifo: in-order queue of owner IDs for one target; pushes into a full queue are dropped.
module rsp_owner_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  import xswitch_pkg::*;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/rsp_xreturn.sv
// rsp_xreturn: steers each target's response burst back to the initiator that owns it,
// with a per-initiator round-robin over targets and a lock held until the last beat.
module rsp_xreturn #(
  parameter int N_INI = xswitch_pkg::N_INI,
  parameter int N_TGT = xswitch_pkg::N_TGT,
  parameter int MAX_OUT = xswitch_pkg::MAX_OUT
) (
  input logic clk,
  input logic rstn,
  rsp_xreturn_if.slave bus
);
  import xswitch_pkg::*;
  localparam int IW = N_INI > 1 ? $clog2(N_INI) : 1;
  localparam int TW = N_TGT > 1 ? $clog2(N_TGT) : 1;
  logic [N_TGT-1:0] push, pop, empty, full;
  logic [N_TGT-1:0][IW-1:0] push_id, head;
  logic [N_INI-1:0][N_TGT-1:0] sel;
  always_comb begin
    push = '0;
    push_id = '0;
    for (int t = 0; t < N_TGT; t++)
      for (int i = 0; i < N_INI; i++)
        if (bus.I_vreq[i][t]) begin
          push[t] = 1'b1;
          push_id[t] = push_id[t] | IW'(i);
        end
  end
  always_comb begin
    bus.T_rsp_rdy = '0;
    bus.I_rsp_vld = '0;
    for (int i = 0; i < N_INI; i++) begin
      bus.I_rsp_vld[i] = |sel[i];
      for (int t = 0; t < N_TGT; t++)
        bus.T_rsp_rdy[t] = bus.T_rsp_rdy[t] | (sel[i][t] & bus.I_rsp_rdy[i]);
    end
  end
  assign pop = bus.T_rsp_rdy & bus.T_rsp_last;
  assign bus.T_ord_full = full;
  assign bus.I_rsp_sel = sel;
  for (genvar t = 0; t < N_TGT; t++) begin : g_tgt
    logic [N_INI-1:0] col;
    always_comb begin
      col = '0;
      for (int i = 0; i < N_INI; i++) col[i] = bus.I_vreq[i][t];
    end
    rsp_owner_fifo #(.DEPTH(MAX_OUT), .WIDTH(IW)) u_fifo (
      .clk(clk),
      .rstn(rstn),
      .push(push[t]),
      .push_data(push_id[t]),
      .pop(pop[t]),
      .head(head[t]),
      .empty(empty[t]),
      .full(full[t])
    );
    a_col_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(col));
    a_no_orphan: assert property (@(posedge clk) disable iff (!rstn) !(bus.T_rsp_vld[t] && empty[t]));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push[t] && full[t]));
  end
  for (genvar i = 0; i < N_INI; i++) begin : g_ini
    logic [N_TGT-1:0] cand, pick;
    logic [TW-1:0] ptr, lock_tgt, tgt;
    logic lock_vld, found, fire;
    always_comb begin
      cand = '0;
      for (int t = 0; t < N_TGT; t++)
        cand[t] = bus.T_rsp_vld[t] & ~empty[t] & (head[t] == IW'(i));
      found = 1'b0;
      tgt = '0;
      // scanning downward lets the nearest candidate after ptr win
      for (int k = N_TGT; k >= 1; k--)
        if (cand[rr_idx(int'(ptr), k, N_TGT)]) begin
          found = 1'b1;
          tgt = TW'(rr_idx(int'(ptr), k, N_TGT));
        end
      found = lock_vld ? cand[lock_tgt] : found;
      tgt = lock_vld ? lock_tgt : tgt;
      pick = '0;
      pick[tgt] = found;
    end
    assign sel[i] = pick;
    assign fire = found & bus.I_rsp_rdy[i];
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
        lock_vld <= 1'b0;
        lock_tgt <= '0;
        ptr <= TW'(N_TGT - 1);
      end else if (fire) begin
        lock_vld <= ~bus.T_rsp_last[tgt];
        lock_tgt <= tgt;
        if (!lock_vld) ptr <= tgt;
      end
    a_row_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(bus.I_vreq[i]));
  end
endmodule

// File: tb/tb_rsp_xreturn.sv
// tb_rsp_xreturn: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_rsp_xreturn;
  localparam int NI = 3;
  localparam int NT = 5;
  localparam int MO = 4;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  rsp_xreturn_if #(.N_INI(NI), .N_TGT(NT)) bus ();
  rsp_xreturn #(.N_INI(NI), .N_TGT(NT), .MAX_OUT(MO)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  int checks = 0;
  int errors = 0;
  int own_q [NT][$];
  int lock_m [NI];
  int ptr_m [NI];
  logic [NI-1:0][NT-1:0] exp_sel;
  logic [NI-1:0] exp_vld;
  logic [NT-1:0] exp_rdy, exp_full;

  function automatic void model_reset();
    for (int t = 0; t < NT; t++) own_q[t].delete();
    for (int i = 0; i < NI; i++) begin
      lock_m[i] = -1;
      ptr_m[i] = NT - 1;
    end
  endfunction

  function automatic bit is_cand(int i, int t);
    return bus.T_rsp_vld[t] && own_q[t].size() > 0 && own_q[t][0] == i;
  endfunction

  function automatic void model_eval();
    exp_rdy = '0;
    for (int i = 0; i < NI; i++) begin
      exp_sel[i] = '0;
      if (lock_m[i] >= 0) exp_sel[i][lock_m[i]] = is_cand(i, lock_m[i]);
      else
        for (int k = 1; k <= NT; k++)
          if (exp_sel[i] == '0 && is_cand(i, (ptr_m[i] + k) % NT)) exp_sel[i][(ptr_m[i] + k) % NT] = 1'b1;
      exp_vld[i] = |exp_sel[i];
      for (int t = 0; t < NT; t++)
        if (exp_sel[i][t] && bus.I_rsp_rdy[i]) exp_rdy[t] = 1'b1;
    end
    for (int t = 0; t < NT; t++) exp_full[t] = own_q[t].size() == MO;
  endfunction

  function automatic void model_commit();
    for (int t = 0; t < NT; t++)
      for (int i = 0; i < NI; i++)
        if (bus.I_vreq[i][t] && own_q[t].size() < MO) own_q[t].push_back(i);
    for (int i = 0; i < NI; i++)
      for (int t = 0; t < NT; t++)
        if (exp_sel[i][t] && bus.I_rsp_rdy[i]) begin
          if (lock_m[i] < 0) ptr_m[i] = t;
          if (bus.T_rsp_last[t]) begin
            void'(own_q[t].pop_front());
            lock_m[i] = -1;
          end else lock_m[i] = t;
        end
  endfunction

  task automatic idle();
    bus.I_vreq = '0;
    bus.T_rsp_vld = '0;
    bus.T_rsp_last = '0;
    bus.I_rsp_rdy = '0;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic push(int i, int t);
    bus.I_vreq = '0;
    bus.I_vreq[i][t] = 1'b1;
    @(negedge clk);
    bus.I_vreq = '0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.I_rsp_vld !== '0) begin errors++; $display("FAIL reset_vld: got %b expected 0", bus.I_rsp_vld); end
    checks++; if (bus.I_rsp_sel !== '0) begin errors++; $display("FAIL reset_sel: got %b expected 0", bus.I_rsp_sel); end
    checks++; if (bus.T_rsp_rdy !== '0) begin errors++; $display("FAIL reset_trdy: got %b expected 0", bus.T_rsp_rdy); end
    checks++; if (bus.T_ord_full !== '0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.T_ord_full); end
    @(negedge clk);
  endtask

  task automatic test_single_beat();
    do_reset();
    bus.I_vreq[1][3] = 1'b1;
    bus.T_rsp_vld[3] = 1'b1;
    bus.T_rsp_last[3] = 1'b1;
    bus.I_rsp_rdy[1] = 1'b1;
    #1;
    checks++; if (bus.T_rsp_rdy !== 5'b00000) begin errors++; $display("FAIL single_no_bypass: got %b expected 00000", bus.T_rsp_rdy); end
    bus.T_rsp_vld[3] = 1'b0;
    @(negedge clk);
    bus.I_vreq = '0;
    bus.T_rsp_vld[3] = 1'b1;
    #1;
    checks++; if (bus.I_rsp_vld !== 3'b010) begin errors++; $display("FAIL single_vld: got %b expected 010", bus.I_rsp_vld); end
    checks++; if (bus.I_rsp_sel[1] !== 5'b01000) begin errors++; $display("FAIL single_sel: got %b expected 01000", bus.I_rsp_sel[1]); end
    checks++; if (bus.T_rsp_rdy !== 5'b01000) begin errors++; $display("FAIL single_trdy: got %b expected 01000", bus.T_rsp_rdy); end
    @(negedge clk);
    #1;
    checks++; if (bus.I_rsp_vld !== 3'b000 || bus.T_rsp_rdy !== 5'b00000) begin errors++; $display("FAIL single_empty_after: vld %b trdy %b expected 000 00000", bus.I_rsp_vld, bus.T_rsp_rdy); end
    idle();
    @(negedge clk);
  endtask

  task automatic test_burst_lock();
    logic [NT-1:0] want [4] = '{5'b00100, 5'b00100, 5'b00100, 5'b00001};
    do_reset();
    push(0, 0);
    push(0, 2);
    bus.I_rsp_rdy[0] = 1'b1;
    bus.T_rsp_vld[2] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (b == 1) begin
        bus.T_rsp_vld[0] = 1'b1;
        bus.T_rsp_last[0] = 1'b1;
      end
      if (b == 2) bus.T_rsp_last[2] = 1'b1;
      if (b == 3) begin
        bus.T_rsp_vld[2] = 1'b0;
        bus.T_rsp_last[2] = 1'b0;
      end
      #1;
      checks++; if (bus.I_rsp_sel[0] !== want[b]) begin errors++; $display("FAIL burst_sel beat %0d: got %b expected %b", b, bus.I_rsp_sel[0], want[b]); end
      if (b == 1) begin
        checks++; if (bus.T_rsp_rdy !== 5'b00100) begin errors++; $display("FAIL burst_trdy: got %b expected 00100", bus.T_rsp_rdy); end
      end
      @(negedge clk);
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [NT-1:0] want [4] = '{5'b00010, 5'b10000, 5'b00010, 5'b10000};
    do_reset();
    push(2, 1);
    push(2, 4);
    push(2, 1);
    push(2, 4);
    bus.T_rsp_vld = 5'b10010;
    bus.T_rsp_last = 5'b10010;
    bus.I_rsp_rdy[2] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (b == 3) bus.T_rsp_vld[1] = 1'b0;
      #1;
      checks++; if (bus.I_rsp_sel[2] !== want[b]) begin errors++; $display("FAIL rr_sel grant %0d: got %b expected %b", b, bus.I_rsp_sel[2], want[b]); end
      @(negedge clk);
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_full_order();
    int owner [4] = '{0, 1, 2, 0};
    do_reset();
    push(0, 0);
    push(1, 0);
    push(2, 0);
    #1;
    checks++; if (bus.T_ord_full !== 5'b00000) begin errors++; $display("FAIL full_three: got %b expected 00000", bus.T_ord_full); end
    @(negedge clk);
    push(0, 0);
    #1;
    checks++; if (bus.T_ord_full !== 5'b00001) begin errors++; $display("FAIL full_four: got %b expected 00001", bus.T_ord_full); end
    @(negedge clk);
    bus.T_rsp_vld[0] = 1'b1;
    bus.T_rsp_last[0] = 1'b1;
    bus.I_rsp_rdy = 3'b111;
    for (int b = 0; b < 4; b++) begin
      #1;
      checks++; if (bus.I_rsp_vld !== 3'(1 << owner[b])) begin errors++; $display("FAIL order_vld rsp %0d: got %b expected %b", b, bus.I_rsp_vld, 3'(1 << owner[b])); end
      checks++; if (bus.T_ord_full[0] !== (b == 0)) begin errors++; $display("FAIL order_full rsp %0d: got %b expected %b", b, bus.T_ord_full[0], b == 0); end
      @(negedge clk);
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_stall();
    do_reset();
    push(1, 2);
    bus.T_rsp_vld[2] = 1'b1;
    bus.T_rsp_last[2] = 1'b1;
    repeat (2) begin
      #1;
      checks++; if (bus.I_rsp_vld !== 3'b010 || bus.T_rsp_rdy !== 5'b00000) begin errors++; $display("FAIL stall_hold: vld %b trdy %b expected 010 00000", bus.I_rsp_vld, bus.T_rsp_rdy); end
      @(negedge clk);
    end
    bus.I_rsp_rdy[1] = 1'b1;
    #1;
    checks++; if (bus.T_rsp_rdy !== 5'b00100) begin errors++; $display("FAIL stall_release: got %b expected 00100", bus.T_rsp_rdy); end
    @(negedge clk);
    idle();
    bus.T_rsp_vld[4] = 1'b1;
    bus.I_rsp_rdy = 3'b111;
    #1;
    checks++; if (bus.T_rsp_rdy !== 5'b00000 || bus.I_rsp_vld !== 3'b000) begin errors++; $display("FAIL orphan: trdy %b vld %b expected 00000 000", bus.T_rsp_rdy, bus.I_rsp_vld); end
    idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    push(0, 1);
    bus.T_rsp_vld[1] = 1'b1;
    bus.I_rsp_rdy[0] = 1'b1;
    #1;
    checks++; if (bus.I_rsp_sel[0] !== 5'b00010) begin errors++; $display("FAIL midrst_first: got %b expected 00010", bus.I_rsp_sel[0]); end
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++; if (bus.I_rsp_vld !== '0 || bus.I_rsp_sel !== '0) begin errors++; $display("FAIL midrst_outs: vld %b sel %b expected 0", bus.I_rsp_vld, bus.I_rsp_sel); end
    checks++; if (bus.T_rsp_rdy !== '0 || bus.T_ord_full !== '0) begin errors++; $display("FAIL midrst_tgt: trdy %b full %b expected 0", bus.T_rsp_rdy, bus.T_ord_full); end
    @(negedge clk);
    idle();
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    push(0, 3);
    bus.T_rsp_vld[3] = 1'b1;
    bus.T_rsp_last[3] = 1'b1;
    bus.I_rsp_rdy[0] = 1'b1;
    #1;
    checks++; if (bus.I_rsp_sel[0] !== 5'b01000) begin errors++; $display("FAIL midrst_unlocked: got %b expected 01000", bus.I_rsp_sel[0]); end
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [NT-1:0] used;
      used = '0;
      idle();
      for (int i = 0; i < NI; i++)
        if ($urandom_range(2) == 0) begin
          int t = $urandom_range(NT - 1);
          if (!used[t] && own_q[t].size() < MO) begin
            bus.I_vreq[i][t] = 1'b1;
            used[t] = 1'b1;
          end
        end
      for (int t = 0; t < NT; t++) begin
        bus.T_rsp_vld[t] = own_q[t].size() > 0 && $urandom_range(3) != 0;
        bus.T_rsp_last[t] = 1'($urandom_range(1));
      end
      for (int i = 0; i < NI; i++) bus.I_rsp_rdy[i] = $urandom_range(3) != 0;
      #1;
      model_eval();
      checks++; if (bus.I_rsp_sel !== exp_sel) begin errors++; $display("FAIL rand_sel cycle %0d: got %b expected %b", c, bus.I_rsp_sel, exp_sel); end
      checks++; if (bus.I_rsp_vld !== exp_vld) begin errors++; $display("FAIL rand_vld cycle %0d: got %b expected %b", c, bus.I_rsp_vld, exp_vld); end
      checks++; if (bus.T_rsp_rdy !== exp_rdy) begin errors++; $display("FAIL rand_trdy cycle %0d: got %b expected %b", c, bus.T_rsp_rdy, exp_rdy); end
      checks++; if (bus.T_ord_full !== exp_full) begin errors++; $display("FAIL rand_full cycle %0d: got %b expected %b", c, bus.T_ord_full, exp_full); end
      model_commit();
      @(negedge clk);
    end
    idle();
    @(negedge clk);
  endtask

  initial begin
    idle();
    test_reset();
    test_single_beat();
    test_burst_lock();
    test_round_robin();
    test_full_order();
    test_stall();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end
endmodule
